// File: rtl/cas_accumulator.sv
// Carry-save accumulator: one addend per cycle into sum/carry registers, single carry-propagate add per group.
// Optional macro CAS_ACC_SPLIT_CPA_EN splits the final add into low/high halves over two cycles.
module cas_accumulator #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned MaxCount  = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [DataWidth-1:0]          Addend,
    input  logic                          InLast,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [DataWidth-1:0]          Result,
    output logic [$clog2(MaxCount+1)-1:0] OutCount
);

    localparam int unsigned cnt_width = $clog2(MaxCount + 1);

`ifdef CAS_ACC_SPLIT_CPA_EN
    localparam int unsigned lo_width = DataWidth / 2;
    localparam int unsigned hi_width = DataWidth - lo_width;

    typedef enum logic [1:0] {ACC, RES_LO, RES_HI, OUT} state_t;

    logic [lo_width-1:0] lo_sum;
    logic                lo_carry;
    logic [hi_width-1:0] hi_sum;
`else
    typedef enum logic [1:0] {ACC, RESOLVE, OUT} state_t;
`endif

    state_t               state;
    state_t               next_state;
    logic [DataWidth-1:0] sum_reg;
    logic [DataWidth-1:0] carry_reg;
    logic [DataWidth-1:0] maj;
    logic [cnt_width-1:0] cnt;
    logic                 accept;
    logic                 group_done;

    assign maj = (sum_reg & carry_reg) | (sum_reg & Addend) | (carry_reg & Addend);

`ifdef CAS_ACC_SPLIT_CPA_EN
    assign hi_sum = hi_width'(sum_reg[DataWidth-1:lo_width] + carry_reg[DataWidth-1:lo_width]
                              + hi_width'(lo_carry));
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        group_done = 1'b0;
        InReady    = 1'b0;
        OutValid   = 1'b0;
        case (state)
            ACC: begin
                InReady    = Rst;
                accept     = InValid && Rst;
                group_done = accept && (InLast || (cnt == cnt_width'(MaxCount - 1)));
                if (group_done) begin
`ifdef CAS_ACC_SPLIT_CPA_EN
                    next_state = RES_LO;
`else
                    next_state = RESOLVE;
`endif
                end
            end
`ifdef CAS_ACC_SPLIT_CPA_EN
            RES_LO: next_state = RES_HI;
            RES_HI: next_state = OUT;
`else
            RESOLVE: next_state = OUT;
`endif
            OUT: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    next_state = ACC;
                end
            end
            default: next_state = ACC;
        endcase
    end

    // Carry-save datapath and result resolution
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sum_reg   <= '0;
            carry_reg <= '0;
            cnt       <= '0;
            Result    <= '0;
            OutCount  <= '0;
`ifdef CAS_ACC_SPLIT_CPA_EN
            lo_sum    <= '0;
            lo_carry  <= 1'b0;
`endif
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        sum_reg   <= sum_reg ^ carry_reg ^ Addend;
                        carry_reg <= maj << 1;
                        cnt       <= cnt + cnt_width'(1);
                    end
                end
`ifdef CAS_ACC_SPLIT_CPA_EN
                RES_LO: begin
                    {lo_carry, lo_sum} <= (lo_width + 1)'(sum_reg[lo_width-1:0])
                                        + (lo_width + 1)'(carry_reg[lo_width-1:0]);
                end
                RES_HI: begin
                    Result    <= {hi_sum, lo_sum};
                    OutCount  <= cnt;
                    sum_reg   <= '0;
                    carry_reg <= '0;
                    cnt       <= '0;
                end
`else
                RESOLVE: begin
                    Result    <= sum_reg + carry_reg;
                    OutCount  <= cnt;
                    sum_reg   <= '0;
                    carry_reg <= '0;
                    cnt       <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
